// File: rtl/reg_list_sequencer_pkg.sv
// Shared CPU definitions for the register-list transfer sequencer:
// state encoding, word size and register-list width helper.
package reg_list_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    localparam int WORD_BYTES = 4;
    localparam int REG_IDX_W  = 4;

    // One mask bit per architectural register.
    function automatic int list_width(input int idx_w);
        return 2 ** idx_w;
    endfunction

endpackage

// File: rtl/reg_list_sequencer_lowest_set_bit.sv
// Combinational priority encoder: index of the lowest set bit of a mask,
// with valid high whenever any bit is set.
module lowest_set_bit
    import reg_list_sequencer_pkg::*;
#(
    parameter int N = REG_IDX_W
) (
    input  logic [list_width(N)-1:0] mask,
    output logic [N-1:0]             idx,
    output logic                     valid
);

    always_comb begin
        idx   = '0;
        valid = |mask;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = list_width(N) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = N'(i);
            end
        end
    end

endmodule

// File: rtl/reg_list_sequencer.sv
// Load/store-multiple sequencer: walks a register mask in ascending order,
// issuing one register-file/memory beat per cycle at consecutive word addresses.
module reg_list_sequencer
    import reg_list_sequencer_pkg::*;
#(
    parameter int N = REG_IDX_W,
    parameter int M = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     load,
    input  logic [list_width(N)-1:0] reg_list,
    input  logic [M-1:0]             base_addr,
    input  logic [M-1:0]             rf_rd,
    input  logic [M-1:0]             mem_rd,
    output logic [N-1:0]             rf_a,
    output logic                     rf_we,
    output logic [M-1:0]             rf_wd,
    output logic [M-1:0]             mem_addr,
    output logic                     mem_we,
    output logic [M-1:0]             mem_wd,
    output logic                     busy,
    output logic                     done,
    output logic [M-1:0]             final_addr
);

    localparam int L = list_width(N);

    // Request protocol: start is taken only while busy is low; the request
    // fields are captured on that same edge and may change freely afterwards.
    seq_state_t     state, state_nxt;
    logic           load_q;
    logic [L-1:0]   mask_q;
    logic [L-1:0]   mask_clr;
    logic [M-1:0]   addr_q;
    logic [N-1:0]   lsb_idx;
    logic           lsb_valid;
    logic           beat;

    lowest_set_bit #(.N(N)) u_lsb (
        .mask  (mask_q),
        .idx   (lsb_idx),
        .valid (lsb_valid)
    );

    assign mask_clr = mask_q & (mask_q - L'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (reg_list != '0) ? ST_XFER : ST_DONE;
                end
            end
            ST_XFER: begin
                if (mask_clr == '0) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_q <= 1'b0;
            mask_q <= '0;
            addr_q <= '0;
        end else if (state == ST_IDLE && start) begin
            load_q <= load;
            mask_q <= reg_list;
            addr_q <= base_addr;
        end else if (beat) begin
            mask_q <= mask_clr;
            addr_q <= addr_q + M'(WORD_BYTES);
        end
    end

    // Address counter has advanced past every beat by the time DONE is reached.
    assign beat       = (state == ST_XFER) && lsb_valid;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign rf_we      = beat && load_q;
    assign mem_we     = beat && !load_q;
    assign rf_a       = beat ? lsb_idx : '0;
    assign mem_addr   = beat ? addr_q : '0;
    assign rf_wd      = mem_rd;
    assign mem_wd     = rf_rd;
    assign final_addr = addr_q;

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Randomised and directed bench for reg_list_sequencer against a
// list-walking reference model with an expected-beat queue.
module tb_reg_list_sequencer;

    localparam int N  = 4;
    localparam int M  = 32;
    localparam int L  = 16;
    localparam int BW = 1 + N + M + M;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          load;
    logic [L-1:0]  reg_list;
    logic [M-1:0]  base_addr;
    logic [M-1:0]  rf_rd;
    logic [M-1:0]  mem_rd;
    logic [N-1:0]  rf_a;
    logic          rf_we;
    logic [M-1:0]  rf_wd;
    logic [M-1:0]  mem_addr;
    logic          mem_we;
    logic [M-1:0]  mem_wd;
    logic          busy;
    logic          done;
    logic [M-1:0]  final_addr;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [BW-1:0] exp_q[$];
    logic [M-1:0]  salt = 32'h1357_9BDF;

    reg_list_sequencer #(.N(N), .M(M)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load       (load),
        .reg_list   (reg_list),
        .base_addr  (base_addr),
        .rf_rd      (rf_rd),
        .mem_rd     (mem_rd),
        .rf_a       (rf_a),
        .rf_we      (rf_we),
        .rf_wd      (rf_wd),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .busy       (busy),
        .done       (done),
        .final_addr (final_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [M-1:0] rf_val(input logic [N-1:0] i, input logic [M-1:0] s);
        return {16'hC0DE, 12'h000, i} ^ s;
    endfunction

    function automatic logic [M-1:0] mem_val(input logic [M-1:0] a, input logic [M-1:0] s);
        return {a[15:0], ~a[31:16]} ^ s;
    endfunction

    function automatic logic [BW-1:0] pack_beat(input logic ld, input logic [N-1:0] i,
                                                 input logic [M-1:0] a, input logic [M-1:0] d);
        return {ld, i, a, d};
    endfunction

    always_comb rf_rd  = rf_val(rf_a, salt);
    always_comb mem_rd = mem_val(mem_addr, salt);

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        start     = 1'($urandom_range(0, 1));
        load      = 1'($urandom_range(0, 1));
        reg_list  = L'($urandom);
        base_addr = $urandom;
    endtask

    // Reference: registers in ascending order, k-th selected register at base + 4*k.
    task automatic build_model(input logic ld, input logic [L-1:0] list,
                               input logic [M-1:0] base, output int p);
        logic [M-1:0] a;
        p = 0;
        for (int i = 0; i < L; i++) begin
            if (list[i]) begin
                a = base + M'(4 * p);
                exp_q.push_back(pack_beat(ld, N'(i), a, ld ? mem_val(a, salt) : rf_val(N'(i), salt)));
                p++;
            end
        end
    endtask

    task automatic check_beat(input logic ld);
        logic [BW-1:0] exp_b;
        logic [BW-1:0] obs_b;
        check_eq("beat_busy", {busy, done}, 2'b10);
        check_eq("beat_strobe", {rf_we, mem_we}, ld ? 2'b10 : 2'b01);
        obs_b = pack_beat(rf_we, rf_a, mem_addr, rf_we ? rf_wd : mem_wd);
        if (exp_q.size() == 0) begin
            check_eq("beat_unexpected", 1, 0);
        end else begin
            exp_b = exp_q.pop_front();
            check_eq("beat", obs_b, exp_b);
        end
    endtask

    task automatic check_quiet(input string tag, input logic exp_busy, input logic exp_done);
        check_eq(tag, {busy, done, rf_we, mem_we}, {exp_busy, exp_done, 2'b00});
    endtask

    // Called at a falling edge; start is taken at the following rising edge.
    task automatic run_xfer(input logic ld, input logic [L-1:0] list, input logic [M-1:0] base);
        int           p;
        logic [M-1:0] exp_final;
        salt      = $urandom;
        start     = 1'b1;
        load      = ld;
        reg_list  = list;
        base_addr = base;
        build_model(ld, list, base, p);
        exp_final = base + M'(4 * p);
        for (int c = 1; c <= p + 2; c++) begin
            @(negedge clk);
            if (c <= p) begin
                check_beat(ld);
            end else if (c == p + 1) begin
                check_quiet("done_cycle", 1'b1, 1'b1);
                check_eq("final_addr", final_addr, exp_final);
            end else begin
                check_quiet("after_done", 1'b0, 1'b0);
            end
            // Requests while busy must be ignored; none may be left pending into IDLE.
            if (c <= p + 1) scramble_inputs();
            else start = 1'b0;
        end
        check_eq("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run_reset_mid_xfer();
        int p;
        salt      = $urandom;
        start     = 1'b1;
        load      = 1'b0;
        reg_list  = 16'h0F00;
        base_addr = 32'h0000_0300;
        build_model(1'b0, reg_list, base_addr, p);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            check_beat(1'b0);
            scramble_inputs();
        end
        start = 1'b0;
        @(negedge clk);
        check_beat(1'b0);
        #1 rst = 1'b1;
        #1;
        check_quiet("rst_strobes", 1'b0, 1'b0);
        check_eq("rst_addr", {rf_a, mem_addr, final_addr}, '0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_quiet("post_rst_idle", 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        load      = 1'b0;
        reg_list  = '0;
        base_addr = '0;
        #12;
        check_quiet("reset_ctrl", 1'b0, 1'b0);
        check_eq("reset_addr", {rf_a, mem_addr, final_addr}, '0);
        @(negedge clk);
        rst = 1'b0;
        // First edge after reset release must accept a request.
        run_xfer(1'b0, 16'h0005, 32'h0000_0100);
        @(negedge clk);
        run_xfer(1'b1, 16'h8001, 32'h0000_0200);
        @(negedge clk);
        run_xfer(1'b0, 16'h0000, 32'h0000_0400);
        @(negedge clk);
        run_xfer(1'b0, 16'h0003, 32'hFFFF_FFFC);
        @(negedge clk);
        run_xfer(1'b1, 16'hFFFF, $urandom);
        @(negedge clk);
        run_xfer(1'b0, 16'hFFFF, 32'hFFFF_FFE0);
        @(negedge clk);
        run_reset_mid_xfer();
        run_xfer(1'b1, 16'h0420, 32'h0000_1000);
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            run_xfer(1'($urandom_range(0, 1)), L'($urandom), $urandom);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/reg_list_sequencer.md
REG_LIST_SEQUENCER -- requirements
Module: reg_list_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: register-index width.
REQ-002 SHALL have parameter M, default 32: data/address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  transfer request, sampled only in IDLE.
REQ-006 SHALL have port load  input  1  1 = load-multiple (memory->registers), 0 = store-multiple; sampled with start.
REQ-007 SHALL have port reg_list  input  2**N  register mask, bit i = register i; sampled with start.
REQ-008 SHALL have port base_addr  input  M  first byte address; sampled with start.
REQ-009 SHALL have port rf_rd  input  M  register-file read data, combinational from rf_a.
REQ-010 SHALL have port mem_rd  input  M  data-memory read data, combinational from mem_addr.
REQ-011 SHALL have port rf_a  output  N  register index: read address on store, write address on load.
REQ-012 SHALL have port rf_we  output  1  register-file write enable.
REQ-013 SHALL have port rf_wd  output  M  register-file write data (= mem_rd).
REQ-014 SHALL have port mem_addr  output  M  data-memory byte address.
REQ-015 SHALL have port mem_we  output  1  data-memory write enable.
REQ-016 SHALL have port mem_wd  output  M  data-memory write data (= rf_rd).
REQ-017 SHALL have port busy  output  1  high in XFER and DONE.
REQ-018 SHALL have port done  output  1  one-cycle completion pulse.
REQ-019 SHALL have port final_addr  output  M  base_addr + 4*popcount(reg_list), valid while done is high.

Function
REQ-020 SHALL implement FSM states IDLE, XFER, DONE.
REQ-021 SHALL, in IDLE with start=1: latch load, reg_list into remaining mask, base_addr into address counter; go to XFER if mask nonzero, else DONE.
REQ-022 SHALL ignore start in XFER and DONE.
REQ-023 SHALL, each XFER cycle, select lowest set bit i of remaining mask (one beat per cycle), drive rf_a=i, mem_addr=address counter.
REQ-024 SHALL, on store beats, assert mem_we=1, rf_we=0, mem_wd=rf_rd.
REQ-025 SHALL, on load beats, assert rf_we=1, mem_we=0, rf_wd=mem_rd.
REQ-026 SHALL, at end of each beat, clear bit i and add 4 to address counter, modulo 2**M (wrap permitted, no flag).
REQ-027 SHALL go XFER->DONE on the beat that clears the last set bit.
REQ-028 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-029 SHALL have latency: start sampled at edge k, beats on cycles k+1..k+P, done on cycle k+P+1 (P = popcount; P=0 gives done at k+1).
REQ-030 SHALL keep rf_we and mem_we at 0 outside XFER; never assert both in one cycle.
REQ-031 SHALL visit registers strictly in ascending index order at ascending addresses.

Reset
REQ-032 SHALL, on rst=1 (any state, any cycle), immediately force IDLE, busy=0, done=0, rf_we=0, mem_we=0, rf_a=0, mem_addr=0, final_addr=0, clear mask and counter.
REQ-033 SHALL abandon an in-progress transfer on reset; beats already committed are not undone.
REQ-034 SHALL accept start on the first rising edge after rst deasserts.

Structure
REQ-035 SHALL take state enum, WORD_BYTES=4 and the list-width constant from the shared CPU package.
REQ-036 SHALL instantiate one sub-module, lowest_set_bit: combinational priority encoder, 2**N-bit mask in, N-bit index plus valid out.

Verification
REQ-037 SHALL cover store: load=0, reg_list=0x0005, base=0x100 -> mem write R0@0x100, R2@0x104; done next cycle; final_addr=0x108.
REQ-038 SHALL cover load: load=1, reg_list=0x8001, base=0x200 -> R0<=mem[0x200], R15<=mem[0x204]; final_addr=0x208.
REQ-039 SHALL cover empty list: reg_list=0x0000 -> done one cycle after start, no write strobes, final_addr=base.
REQ-040 SHALL cover wrap: base=0xFFFFFFFC, reg_list=0x0003, store -> addresses 0xFFFFFFFC then 0x00000000; final_addr=0x00000004.
REQ-041 SHALL cover full list: reg_list=0xFFFF -> 16 consecutive beats, done at cycle 17 after start; start pulses mid-transfer ignored.
REQ-042 SHALL cover reset mid-XFER: rst after 2 of 4 beats -> strobes drop same cycle, busy=0, no further beats or done.
